// File: rtl/sdram_arb_pkg.sv
// Shared widths, FSM state encoding and bank-bit default for the SDRAM frame arbiter.
package sdram_arb_pkg;
  localparam int unsigned ADDR_W       = 24;
  localparam int unsigned LEN_W        = 10;
  localparam int unsigned BANK_BIT_DEF = 23;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_REQ   = 3'd1,
    ST_WR_BURST = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_BURST = 3'd4
  } arb_state_e;
endpackage

// File: rtl/sdram_addr_gen.sv
// Frame address counter: load to start, step by burst length, wrap to start at the frame end.
module sdram_addr_gen
  import sdram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_min,
  input  logic [ADDR_W-1:0] i_max,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wrap_c
);
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   w_sum;
  logic              w_past_end;

  // One extra bit so the end-of-frame compare cannot overflow.
  always_comb begin
    w_sum      = {1'b0, r_addr} + (ADDR_W+1)'(i_len);
    w_past_end = w_sum >= {1'b0, i_max};
    o_wrap_c   = i_inc && !i_load && w_past_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_min;
    end else if (i_inc) begin
      r_addr <= w_past_end ? i_min : w_sum[ADDR_W-1:0];
    end
  end

  assign o_addr = r_addr;
endmodule

// File: rtl/sdram_frame_arbiter.sv
// Shares one SDRAM command channel between camera writes and display reads,
// with fixed-length bursts, wrapping frame addresses and ping-pong frame banks.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter logic [LEN_W-1:0] WR_LEN   = 10'd512,
  parameter logic [LEN_W-1:0] RD_LEN   = 10'd512,
  parameter int unsigned      BANK_BIT = BANK_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              read_valid,
  input  logic              pingpang_en,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [ADDR_W-1:0] wr_min_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_min_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic [LEN_W-1:0]  wr_fifo_cnt,
  input  logic [LEN_W-1:0]  rd_fifo_cnt,
  output logic              cmd_req,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_ack,
  input  logic              cmd_done
);
  arb_state_e        r_state;
  logic              r_cmd_req, r_cmd_wr;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [LEN_W-1:0]  r_cmd_len;
  logic              r_last_rd, r_wr_bank, r_rd_bank, r_frame_rdy;
  logic              r_wr_load_pend, r_rd_load_pend;

  logic              w_wr_pend, w_rd_pend, w_wr_in_burst, w_rd_in_burst;
  logic              w_wr_done, w_rd_done, w_wr_load, w_rd_load, w_wr_wrap, w_rd_wrap;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr, w_wr_cmd_addr, w_rd_cmd_addr;

  // A load seen once the burst is committed is deferred to its cmd_done.
  always_comb begin
    w_wr_pend     = (wr_fifo_cnt >= WR_LEN) && !wr_load;
    w_rd_pend     = read_valid && (rd_fifo_cnt < RD_LEN) && !rd_load;
    w_wr_in_burst = (r_state == ST_WR_BURST) || ((r_state == ST_WR_REQ) && cmd_ack);
    w_rd_in_burst = (r_state == ST_RD_BURST) || ((r_state == ST_RD_REQ) && cmd_ack);
    w_wr_done     = (r_state == ST_WR_BURST) && cmd_done;
    w_rd_done     = (r_state == ST_RD_BURST) && cmd_done;
    w_wr_load     = (wr_load && !w_wr_in_burst) || (w_wr_done && (wr_load || r_wr_load_pend));
    w_rd_load     = (rd_load && !w_rd_in_burst) || (w_rd_done && (rd_load || r_rd_load_pend));
    w_wr_cmd_addr = w_wr_addr;
    w_wr_cmd_addr[BANK_BIT] = pingpang_en && r_wr_bank;
    w_rd_cmd_addr = w_rd_addr;
    w_rd_cmd_addr[BANK_BIT] = pingpang_en && r_rd_bank;
  end

  sdram_addr_gen u_wr_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_wr_load),
    .i_inc   (w_wr_done),
    .i_min   (wr_min_addr),
    .i_max   (wr_max_addr),
    .i_len   (WR_LEN),
    .o_addr  (w_wr_addr),
    .o_wrap_c(w_wr_wrap)
  );

  sdram_addr_gen u_rd_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_rd_load),
    .i_inc   (w_rd_done),
    .i_min   (rd_min_addr),
    .i_max   (rd_max_addr),
    .i_len   (RD_LEN),
    .o_addr  (w_rd_addr),
    .o_wrap_c(w_rd_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd_req  <= 1'b0;
      r_cmd_wr   <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_len  <= '0;
      r_last_rd  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (init_done) begin
            if (w_wr_pend && (!w_rd_pend || r_last_rd)) begin
              r_state    <= ST_WR_REQ;
              r_cmd_req  <= 1'b1;
              r_cmd_wr   <= 1'b1;
              r_cmd_addr <= w_wr_cmd_addr;
              r_cmd_len  <= WR_LEN;
            end else if (w_rd_pend) begin
              r_state    <= ST_RD_REQ;
              r_cmd_req  <= 1'b1;
              r_cmd_wr   <= 1'b0;
              r_cmd_addr <= w_rd_cmd_addr;
              r_cmd_len  <= RD_LEN;
            end
          end
        end
        ST_WR_REQ: begin
          if (cmd_ack) begin
            r_state   <= ST_WR_BURST;
            r_cmd_req <= 1'b0;
          end else if (wr_load) begin
            r_state   <= ST_IDLE;
            r_cmd_req <= 1'b0;
          end
        end
        ST_WR_BURST: begin
          if (cmd_done) begin
            r_state   <= ST_IDLE;
            r_last_rd <= 1'b0;
          end
        end
        ST_RD_REQ: begin
          if (cmd_ack) begin
            r_state   <= ST_RD_BURST;
            r_cmd_req <= 1'b0;
          end else if (rd_load) begin
            r_state   <= ST_IDLE;
            r_cmd_req <= 1'b0;
          end
        end
        ST_RD_BURST: begin
          if (cmd_done) begin
            r_state   <= ST_IDLE;
            r_last_rd <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_load_pend <= 1'b0;
      r_rd_load_pend <= 1'b0;
    end else begin
      if (w_wr_done)                     r_wr_load_pend <= 1'b0;
      else if (wr_load && w_wr_in_burst) r_wr_load_pend <= 1'b1;
      if (w_rd_done)                     r_rd_load_pend <= 1'b0;
      else if (rd_load && w_rd_in_burst) r_rd_load_pend <= 1'b1;
    end
  end

  // Reads switch to the just-finished frame only at their own wrap; otherwise they repeat the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_frame_rdy <= 1'b0;
    end else if (w_wr_wrap) begin
      if (pingpang_en) r_wr_bank <= ~r_wr_bank;
      r_frame_rdy <= 1'b1;
    end else if (w_rd_wrap && r_frame_rdy) begin
      r_rd_bank   <= ~r_wr_bank;
      r_frame_rdy <= 1'b0;
    end
  end

  assign cmd_req  = r_cmd_req;
  assign cmd_wr   = r_cmd_wr;
  assign cmd_addr = r_cmd_addr;
  assign cmd_len  = r_cmd_len;
endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter: grants, latency, address wrap, ping-pong banks, loads, reset.
module tb_sdram_frame_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b1;
  logic        read_valid = 1'b0;
  logic        pingpang_en = 1'b1;
  logic        wr_load = 1'b0;
  logic        rd_load = 1'b0;
  logic [23:0] wr_min_addr = 24'd0;
  logic [23:0] wr_max_addr = 24'd1024;
  logic [23:0] rd_min_addr = 24'd0;
  logic [23:0] rd_max_addr = 24'd1024;
  logic [9:0]  wr_fifo_cnt = 10'd0;
  logic [9:0]  rd_fifo_cnt = 10'd600;
  logic        cmd_req, cmd_wr;
  logic [23:0] cmd_addr;
  logic [9:0]  cmd_len;
  logic        cmd_ack = 1'b0;
  logic        cmd_done = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_frame_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .read_valid (read_valid),
    .pingpang_en(pingpang_en),
    .wr_load    (wr_load),
    .rd_load    (rd_load),
    .wr_min_addr(wr_min_addr),
    .wr_max_addr(wr_max_addr),
    .rd_min_addr(rd_min_addr),
    .rd_max_addr(rd_max_addr),
    .wr_fifo_cnt(wr_fifo_cnt),
    .rd_fifo_cnt(rd_fifo_cnt),
    .cmd_req    (cmd_req),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_ack    (cmd_ack),
    .cmd_done   (cmd_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the next request and check its latency and fields.
  task automatic grant(input string tag, input logic exp_wr, input logic [23:0] exp_addr);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cmd_req && cyc < 20);
    chk({tag, "_lat"},  32'(cyc), 32'd1);
    chk({tag, "_wr"},   32'(cmd_wr), 32'(exp_wr));
    chk({tag, "_addr"}, 32'(cmd_addr), 32'(exp_addr));
    chk({tag, "_len"},  32'(cmd_len), 32'd512);
  endtask

  // Controller side: ack after ack_dly cycles, done pulse after done_dly; optional wr_load mid-burst.
  task automatic finish_burst(input string tag, input int ack_dly, input int done_dly,
                              input bit load_mid);
    logic [23:0] held;
    held = cmd_addr;
    repeat (ack_dly) @(negedge clk);
    chk({tag, "_req_hold"}, 32'(cmd_req), 32'd1);
    chk({tag, "_addr_hold"}, 32'(cmd_addr), 32'(held));
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    chk({tag, "_req_drop"}, 32'(cmd_req), 32'd0);
    if (load_mid) begin
      wr_load = 1'b1;
      @(negedge clk);
      wr_load = 1'b0;
      chk({tag, "_no_abort"}, 32'(cmd_req), 32'd0);
    end
    repeat (done_dly) @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
  endtask

  initial begin
    int quiet;
    repeat (2) @(negedge clk);
    chk("rst_req",  32'(cmd_req), 32'd0);
    chk("rst_wr",   32'(cmd_wr), 32'd0);
    chk("rst_addr", 32'(cmd_addr), 32'd0);
    chk("rst_len",  32'(cmd_len), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // Stray done/ack while idle must be ignored.
    cmd_done = 1'b1; cmd_ack = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0; cmd_ack = 1'b0;
    @(negedge clk);
    chk("idle_req", 32'(cmd_req), 32'd0);

    // Write-only traffic, frame = 2 bursts: 0, 512, wrap -> bank 1.
    wr_fifo_cnt = 10'd512;
    grant("w1", 1'b1, 24'h000000);
    finish_burst("w1", 3, 2, 1'b0);
    grant("w2", 1'b1, 24'h000200);
    finish_burst("w2", 1, 1, 1'b0);
    grant("w3", 1'b1, 24'h800000);
    wr_fifo_cnt = 10'd0;
    finish_burst("w3", 1, 1, 1'b0);

    // Both pending: last grant was write, so R,W,R,W with one idle cycle between.
    wr_fifo_cnt = 10'd512;
    read_valid  = 1'b1;
    rd_fifo_cnt = 10'd0;
    grant("r1", 1'b0, 24'h000000);
    finish_burst("r1", 1, 1, 1'b0);
    grant("w4", 1'b1, 24'h800200);
    finish_burst("w4", 1, 1, 1'b0);
    grant("r2", 1'b0, 24'h000200);
    finish_burst("r2", 1, 1, 1'b0);
    grant("w5", 1'b1, 24'h000000);
    finish_burst("w5", 1, 1, 1'b0);

    // Read wrapped with frame ready -> bank = ~wr bank = 1; next wrap without a new frame keeps it.
    grant("r3", 1'b0, 24'h800000);
    wr_fifo_cnt = 10'd0;
    finish_burst("r3", 1, 1, 1'b0);
    grant("r4", 1'b0, 24'h800200);
    finish_burst("r4", 1, 1, 1'b0);
    grant("r5", 1'b0, 24'h800000);
    read_valid = 1'b0;
    finish_burst("r5", 1, 1, 1'b0);

    // wr_load mid-burst: burst completes, next write restarts at the new frame start.
    wr_min_addr = 24'h000100;
    wr_fifo_cnt = 10'd512;
    grant("w6", 1'b1, 24'h000200);
    finish_burst("w6", 1, 2, 1'b1);
    grant("w7", 1'b1, 24'h000100);

    // init_done low during the burst: finish it, then stay idle despite both pending.
    init_done  = 1'b0;
    read_valid = 1'b1;
    finish_burst("w7", 1, 1, 1'b0);
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!cmd_req) quiet++;
    end
    chk("init_low_quiet", 32'(quiet), 32'd6);
    init_done = 1'b1;
    grant("r6", 1'b0, 24'h800200);

    // Asynchronous reset while a read request is outstanding.
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",  32'(cmd_req), 32'd0);
    chk("async_rst_wr",   32'(cmd_wr), 32'd0);
    chk("async_rst_addr", 32'(cmd_addr), 32'd0);
    chk("async_rst_len",  32'(cmd_len), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
